edac_crc_encoder: RTL and testbench
===================================

# edac_crc_encoder

Bit-serial CRC-8 encoder that sits directly upstream of the EDAC decoder: accepts a data word, computes its CRC over the generator polynomial one bit per clock, and presents the codeword {data, crc} to the decoder's data input. Input and output both use valid/ready handshakes. `out_valid` is the intended source of the decoder's `en`.

## Interface
- `DATA_W`, default 24: data bits per codeword.
- `CRC_W`, default 8: CRC width. The codeword width is `DATA_W+CRC_W`, which is 32 at the defaults.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `CRC_POLY`  in  CRC_W  generator polynomial without the implicit x^CRC_W term; the system value is 8'h97. Sampled only on the accept edge.
- `Din`  in  DATA_W  data word to encode.
- `in_valid`  in  1  `Din` is valid.
- `in_ready`  out  1  encoder can accept a word; equals (state==IDLE) && !rst.
- `Dout`  out  DATA_W+CRC_W  codeword {data[DATA_W-1:0], crc[CRC_W-1:0]}.
- `out_valid`  out  1  `Dout` holds a finished codeword.
- `out_ready`  in  1  consumer takes `Dout`.
- `busy`  out  1  high in the CALC state.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: one data bit per cycle.
  - DONE: out_valid=1; `Dout` is held.
- IDLE→CALC when `in_valid && in_ready` at a rising edge (the accept edge). On that edge:
  - data_hold ← `Din`; shreg ← `Din`; poly_q ← `CRC_POLY`; crc ← 0; bitcnt ← 0.
- CALC, each edge, data MSB first:
  - b = shreg[DATA_W-1]; fb = crc[CRC_W-1] ^ b.
  - crc ← {crc[CRC_W-2:0],1'b0} ^ (fb ? poly_q : 0).
  - shreg ← shreg << 1; bitcnt ← bitcnt+1.
- CRC convention: initial value 0, no input or output reflection, no final XOR. This is equivalent to the remainder of data(x)·x^CRC_W mod P(x).
- CALC→DONE on the edge that processes bit index DATA_W-1 (bitcnt==DATA_W-1). On the same edge, `Dout` ← {data_hold, crc_next}.
- DONE→IDLE on the edge where `out_ready` is high. `Dout` keeps its value after leaving DONE until the next DONE load.
- `bitcnt` width is clog2(DATA_W) (5 bits at the default). It never wraps in normal operation; it is cleared on accept.
- Changes to `Din`, `CRC_POLY` or `in_valid` during CALC/DONE are ignored. No second word is accepted before the DONE handshake; there is no skid buffer.
- `out_ready` in IDLE or CALC has no effect.

## Timing
- Reset values: state=IDLE, `Dout`=0, `out_valid`=0, `busy`=0, `in_ready`=0 while `rst` is high, crc/shreg/bitcnt/poly_q=0.
- `in_ready` rises combinationally when `rst` deasserts.
- Latency: `out_valid` rises on the DATA_W-th rising edge after the accept edge, i.e. the 24th at the default.
- Throughput: one codeword per DATA_W+2 cycles minimum when `out_ready` is tied high:
  - accept edge → 24 CALC edges → 1 DONE edge → `in_ready` high again in the following cycle.
- `out_valid` is registered and stays high through any number of `out_ready`-low cycles. `Dout` is stable for the whole of DONE.
- `busy` is high in exactly the cycles after the accept edge up to and including the cycle before `out_valid` rises, which is DATA_W cycles.
- `rst` asserted mid-CALC or mid-DONE immediately clears all state and outputs. The in-flight word is discarded and no `out_valid` pulse is produced.

## Test plan
- Reset, then `CRC_POLY`=8'h97, `Din`=24'h0002FA, `in_valid` for 1 cycle. Required:
  - `busy` high for 24 cycles;
  - `out_valid` rises 24 edges after accept;
  - `Dout`=32'h0002FA7F.
- `Din`=24'h000001 → `Dout`=32'h00000197. `Din`=24'h000000 → `Dout`=32'h00000000.
- Hold `out_ready` low for 10 cycles in DONE with `in_valid` high and a new `Din`. Required:
  - `Dout` and `out_valid` stay unchanged;
  - `in_ready` stays 0;
  - the new word is accepted only in IDLE after the handshake.
- Change `CRC_POLY` to 8'h07 and `Din` to a different value on the cycle after accept of 24'h0002FA. Required: `Dout`=32'h0002FA7F, because the latched values are used.
- Assert `rst` at CALC bit 12. Required:
  - `Dout`=0, `out_valid`=0, `busy`=0 immediately;
  - after release, a fresh 24'h0002FA encodes to 32'h0002FA7F.
- Back-to-back: `in_valid` and `out_ready` tied high for 3 words. Required:
  - accept edges spaced 26 cycles apart;
  - each `Dout` feeds the decoder with `en`=`out_valid`, and the decoder reports valid for every word.

Source files
------------

// File: rtl/edac_crc_encoder.sv
// Bit-serial CRC encoder feeding the EDAC decoder: latches a data word, shifts it
// MSB first through a CRC LFSR one bit per clock, then presents {data, crc}.
module edac_crc_encoder #(
  parameter int DATA_W = 24,
  parameter int CRC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CRC_W-1:0]          CRC_POLY,
  input  logic [DATA_W-1:0]         Din,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W+CRC_W-1:0]   Dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] data_hold;
  logic [DATA_W-1:0] shreg;
  logic [CRC_W-1:0]  poly_q;
  logic [CRC_W-1:0]  crc;
  logic [CRC_W-1:0]  crc_next;
  logic [CNT_W-1:0]  bitcnt;
  logic              accept;
  logic              last_bit;

  // One LFSR step: shift left, fold the polynomial in when the outgoing bit
  // differs from the incoming data bit.
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] crc_in,
    input logic             data_bit,
    input logic [CRC_W-1:0] poly
  );
    logic fb;
    fb = crc_in[CRC_W-1] ^ data_bit;
    return {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == CALC) && (bitcnt == LAST_BIT);
  assign crc_next = crc_step(crc, shreg[DATA_W-1], poly_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (bitcnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accept stage latches operands; CALC stage consumes one data bit per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_hold <= '0;
      shreg     <= '0;
      poly_q    <= '0;
      crc       <= '0;
      bitcnt    <= '0;
      Dout      <= '0;
    end else if (accept) begin
      data_hold <= Din;
      shreg     <= Din;
      poly_q    <= CRC_POLY;
      crc       <= '0;
      bitcnt    <= '0;
    end else if (state == CALC) begin
      crc    <= crc_next;
      shreg  <= shreg << 1;
      bitcnt <= bitcnt + CNT_W'(1);
      if (last_bit) Dout <= {data_hold, crc_next};
    end
  end

endmodule

// File: tb/tb_edac_crc_encoder.sv
// Bench for edac_crc_encoder: CRC checked against polynomial long division,
// decoder acceptance modelled as a zero remainder over the whole codeword.
module tb_edac_crc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  CRC_POLY;
  logic [23:0] Din;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Dout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  edac_crc_encoder #(.DATA_W(24), .CRC_W(8)) dut (
    .clk(clk), .rst(rst), .CRC_POLY(CRC_POLY), .Din(Din), .in_valid(in_valid),
    .in_ready(in_ready), .Dout(Dout), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // Remainder of cw(x) mod (x^8 + poly) by long division.
  function automatic logic [7:0] ref_rem(input logic [31:0] cw, input logic [7:0] poly);
    logic [31:0] r;
    logic [8:0]  g;
    r = cw;
    g = {1'b1, poly};
    for (int i = 31; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ g;
    end
    return r[7:0];
  endfunction

  function automatic logic [31:0] ref_codeword(input logic [23:0] d, input logic [7:0] poly);
    return {d, ref_rem({d, 8'h00}, poly)};
  endfunction

  // Accept one word, then wait (bounded) for out_valid; leaves us at a negedge in DONE.
  task automatic start_and_wait(input logic [23:0] d, input logic [7:0] p, input bit perturb,
                                output int edges, output int busy_cnt);
    @(negedge clk);
    Din = d; CRC_POLY = p; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (perturb) begin
      CRC_POLY = 8'h07; Din = 24'h5A5A5A;
    end
    edges = 0; busy_cnt = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 24) begin
      fails++; $display("FAIL latency: out_valid after %0d edges required 24", edges);
    end
  endtask

  task automatic do_handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Din = '0; CRC_POLY = 8'h97;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Dout !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: Dout=%h out_valid=%b busy=%b in_ready=%b required 0/0/0/0",
               Dout, out_valid, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_known_vectors();
    logic [23:0] d [3];
    logic [31:0] e [3];
    int edges, bc;
    d[0] = 24'h0002FA; e[0] = 32'h0002FA7F;
    d[1] = 24'h000001; e[1] = 32'h00000197;
    d[2] = 24'h000000; e[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(d[i], 8'h97, 1'b0, edges, bc);
      checks++;
      if (bc !== 24) begin
        fails++; $display("FAIL busy_cycles[%0d]: %0d required 24", i, bc);
      end
      checks++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL busy_in_done[%0d]: busy=%b required 0", i, busy);
      end
      checks++;
      if (Dout !== e[i]) begin
        fails++; $display("FAIL vector[%0d]: Dout=%h required %h", i, Dout, e[i]);
      end
      do_handshake();
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    logic [7:0]  p;
    logic [31:0] exp_cw;
    int edges, bc;
    for (int i = 0; i < 6; i++) begin
      d = 24'($urandom);
      p = (i % 2 == 0) ? 8'h97 : 8'($urandom);
      exp_cw = ref_codeword(d, p);
      start_and_wait(d, p, 1'b0, edges, bc);
      checks++;
      if (Dout !== exp_cw) begin
        fails++; $display("FAIL random[%0d]: Dout=%h required %h (poly %h)", i, Dout, exp_cw, p);
      end
      do_handshake();
    end
  endtask

  task automatic test_hold_done();
    logic [23:0] nd;
    int edges, bc, waited;
    bit held_ok;
    start_and_wait(24'h0002FA, 8'h97, 1'b0, edges, bc);
    nd = 24'($urandom);
    Din = nd; in_valid = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (Dout !== 32'h0002FA7F || out_valid !== 1'b1 || in_ready !== 1'b0) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      fails++;
      $display("FAIL hold_done: Dout=%h out_valid=%b in_ready=%b required 0002fa7f/1/0",
               Dout, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL hold_to_idle: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL hold_accept: busy=%b required 1", busy);
    end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    checks++;
    if (Dout !== ref_codeword(nd, 8'h97)) begin
      fails++; $display("FAIL hold_new_word: Dout=%h required %h", Dout, ref_codeword(nd, 8'h97));
    end
    do_handshake();
  endtask

  task automatic test_latched_inputs();
    int edges, bc;
    start_and_wait(24'h0002FA, 8'h97, 1'b1, edges, bc);
    checks++;
    if (Dout !== 32'h0002FA7F) begin
      fails++; $display("FAIL latched_inputs: Dout=%h required 0002fa7f", Dout);
    end
    CRC_POLY = 8'h97;
    do_handshake();
  endtask

  task automatic test_reset_mid();
    int edges, bc;
    bit stray;
    @(negedge clk);
    Din = 24'h0002FA; CRC_POLY = 8'h97; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (Dout !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: Dout=%h out_valid=%b busy=%b in_ready=%b required 0/0/0/0",
               Dout, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      fails++; $display("FAIL reset_discard: out_valid or busy seen after reset, required 0");
    end
    start_and_wait(24'h0002FA, 8'h97, 1'b0, edges, bc);
    checks++;
    if (Dout !== 32'h0002FA7F) begin
      fails++; $display("FAIL reset_fresh: Dout=%h required 0002fa7f", Dout);
    end
    do_handshake();
  endtask

  task automatic test_back_to_back();
    logic [23:0] q[$];
    logic [23:0] d;
    logic [31:0] exp_cw;
    int acc_cyc [3];
    int na, outs, cyc;
    bit last_acc;
    @(negedge clk);
    Din = 24'($urandom); CRC_POLY = 8'h97; in_valid = 1'b1; out_ready = 1'b1;
    na = 0; outs = 0; cyc = 0; last_acc = 1'b0;
    while (outs < 3 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        d = q.pop_front();
        exp_cw = ref_codeword(d, 8'h97);
        checks++;
        if (Dout !== exp_cw) begin
          fails++; $display("FAIL b2b_dout[%0d]: Dout=%h required %h", outs, Dout, exp_cw);
        end
        checks++;
        if (ref_rem(Dout, 8'h97) !== 8'h00) begin
          fails++; $display("FAIL b2b_decoder[%0d]: syndrome=%h required 00", outs, ref_rem(Dout, 8'h97));
        end
        outs++;
      end
      last_acc = 1'b0;
      if (in_valid === 1'b1 && in_ready === 1'b1 && na < 3) begin
        acc_cyc[na] = cyc;
        q.push_back(Din);
        na++;
        last_acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (last_acc) begin
        if (na < 3) Din = 24'($urandom);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (outs !== 3 || na !== 3) begin
      fails++; $display("FAIL b2b_count: outputs=%0d accepts=%0d required 3/3", outs, na);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 26) begin
          fails++; $display("FAIL b2b_spacing[%0d]: %0d cycles required 26", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_hold_done();
    test_latched_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
